// File: rtl/hwt_seq_trigger.sv
// hwt_seq_trigger: registered A..D stage that counts A,5,F sequences and kills D after THRESH hits
module hwt_seq_trigger #(
    parameter logic [3:0] P0     = 4'hA,
    parameter logic [3:0] P1     = 4'h5,
    parameter logic [3:0] P2     = 4'hF,
    parameter int         THRESH = 3,
    parameter int         CNT_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             A,
    input  logic             B,
    input  logic             C,
    input  logic             D,
    output logic             A_o,
    output logic             B_o,
    output logic             C_o,
    output logic             D_o,
    output logic             trig,
    output logic [CNT_W-1:0] match_cnt
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_S1    = 2'd1;
    localparam logic [1:0] S_S2    = 2'd2;
    localparam logic [1:0] S_FIRED = 2'd3;

    logic [1:0]       r_state;
    logic [1:0]       w_next;
    logic [3:0]       r_q;
    logic [CNT_W-1:0] r_cnt;
    logic             r_trig;
    logic [3:0]       w_v;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_hit;
    logic             w_fire;

    assign w_v       = {A, B, C, D};
    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_hit     = en && r_state == S_S2 && w_v == P2;
    assign w_fire    = w_hit && w_cnt_inc == CNT_W'(THRESH);

    // Sequence monitor next state: completion beats P0 restart beats falling back to IDLE
    always_comb begin
        w_next = r_state;
        if (r_state != S_FIRED && en)
            w_next = w_hit ? (w_fire ? S_FIRED : S_IDLE)
                   : (r_state == S_S1 && w_v == P1) ? S_S2
                   : (w_v == P0) ? S_S1 : S_IDLE;
    end

    // Input pipeline, FSM state, occurrence counter and sticky trigger
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q     <= '0;
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_trig  <= 1'b0;
        end else begin
            r_q     <= w_v;
            r_state <= w_next;
            if (w_hit)
                r_cnt <= w_cnt_inc;
            if (w_fire)
                r_trig <= 1'b1;
        end
    end

    assign A_o       = r_q[3];
    assign B_o       = r_q[2];
    assign C_o       = r_q[1];
    assign D_o       = r_q[0] & ~r_trig;
    assign trig      = r_trig;
    assign match_cnt = r_cnt;
endmodule

// File: tb/tb_hwt_seq_trigger.sv
// tb_hwt_seq_trigger: scenario tasks with a queue of expected {A_o..D_o, trig, match_cnt}
module tb_hwt_seq_trigger;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       A = 1'b0, B = 1'b0, C = 1'b0, D = 1'b0;
    logic       A_o, B_o, C_o, D_o, trig;
    logic [3:0] match_cnt;
    logic [8:0] exp_q[$];
    logic [8:0] got, e;
    int         checks = 0;
    int         errors = 0;

    hwt_seq_trigger dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .A(A), .B(B), .C(C), .D(D),
        .A_o(A_o), .B_o(B_o), .C_o(C_o), .D_o(D_o),
        .trig(trig), .match_cnt(match_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] pk(input logic [3:0] q, input logic t, input logic [3:0] c);
        return {q, t, c};
    endfunction

    task automatic cyc(input logic r, input logic e_in, input logic [3:0] v);
        @(negedge clk);
        rst_n = r;
        en = e_in;
        {A, B, C, D} = v;
        @(posedge clk);
        #1;
        got = {A_o, B_o, C_o, D_o, trig, match_cnt};
    endtask

    task automatic test_reset();
        logic       r[3]  = '{1'b0, 1'b0, 1'b1};
        logic [8:0] ex[3] = '{pk(4'h0, 0, 0), pk(4'h0, 0, 0), pk(4'hF, 0, 0)};
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(ex[i]);
            cyc(r[i], 1'b0, 4'hF);
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL reset[%0d] got %h expected %h", i, got, e);
            end
        end
    endtask

    task automatic test_pass();
        logic [3:0] v[2]  = '{4'hD, 4'h3};
        logic [8:0] ex[2] = '{pk(4'hD, 0, 0), pk(4'h3, 0, 0)};
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(ex[i]);
            cyc(1'b1, 1'b0, v[i]);
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL pass[%0d] got %h expected %h", i, got, e);
            end
            if (i == 0) begin
                checks++;
                if ((D_o & ((A_o & B_o) | C_o)) !== 1'b1) begin
                    errors++;
                    $display("FAIL pass_y got %b expected 1", D_o & ((A_o & B_o) | C_o));
                end
            end
        end
    endtask

    task automatic test_fire();
        logic [3:0] v[13] = '{4'hA, 4'h5, 4'hF, 4'hA, 4'h5, 4'hF, 4'hA, 4'h5, 4'hF,
                              4'hF, 4'hA, 4'h5, 4'hF};
        logic [8:0] ex[13] = '{pk(4'hA, 0, 0), pk(4'h5, 0, 0), pk(4'hF, 0, 1),
                               pk(4'hA, 0, 1), pk(4'h5, 0, 1), pk(4'hF, 0, 2),
                               pk(4'hA, 0, 2), pk(4'h5, 0, 2), pk(4'hE, 1, 3),
                               pk(4'hE, 1, 3), pk(4'hA, 1, 3), pk(4'h4, 1, 3), pk(4'hE, 1, 3)};
        for (int i = 0; i < 13; i++) begin
            exp_q.push_back(ex[i]);
            cyc(1'b1, 1'b1, v[i]);
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL fire[%0d] got %h expected %h", i, got, e);
            end
        end
    endtask

    task automatic test_reset_fired();
        logic       r[4]  = '{1'b0, 1'b1, 1'b1, 1'b1};
        logic [3:0] v[4]  = '{4'h0, 4'hA, 4'h5, 4'hF};
        logic [8:0] ex[4] = '{pk(4'h0, 0, 0), pk(4'hA, 0, 0), pk(4'h5, 0, 0), pk(4'hF, 0, 1)};
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(ex[i]);
            cyc(r[i], 1'b1, v[i]);
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL reset_fired[%0d] got %h expected %h", i, got, e);
            end
        end
    endtask

    task automatic test_nomatch_overlap();
        logic       r[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [3:0] v[9]  = '{4'h0, 4'hA, 4'h5, 4'h3, 4'hF, 4'hA, 4'hA, 4'h5, 4'hF};
        logic [8:0] ex[9] = '{pk(4'h0, 0, 0), pk(4'hA, 0, 0), pk(4'h5, 0, 0), pk(4'h3, 0, 0),
                              pk(4'hF, 0, 0), pk(4'hA, 0, 0), pk(4'hA, 0, 0), pk(4'h5, 0, 0),
                              pk(4'hF, 0, 1)};
        for (int i = 0; i < 9; i++) begin
            exp_q.push_back(ex[i]);
            cyc(r[i], 1'b1, v[i]);
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL nomatch_overlap[%0d] got %h expected %h", i, got, e);
            end
        end
    endtask

    task automatic test_en_gap();
        logic       r[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic       g[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [3:0] v[6]  = '{4'h0, 4'hA, 4'hF, 4'hF, 4'h5, 4'hF};
        logic [8:0] ex[6] = '{pk(4'h0, 0, 0), pk(4'hA, 0, 0), pk(4'hF, 0, 0), pk(4'hF, 0, 0),
                              pk(4'h5, 0, 0), pk(4'hF, 0, 1)};
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(ex[i]);
            cyc(r[i], g[i], v[i]);
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL en_gap[%0d] got %h expected %h", i, got, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic       r[10]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [3:0] v[10]  = '{4'h0, 4'hA, 4'h5, 4'hA, 4'h5, 4'hF, 4'hA, 4'h3, 4'h5, 4'hF};
        logic [8:0] ex[10] = '{pk(4'h0, 0, 0), pk(4'hA, 0, 0), pk(4'h5, 0, 0), pk(4'hA, 0, 0),
                               pk(4'h5, 0, 0), pk(4'hF, 0, 1), pk(4'hA, 0, 1), pk(4'h3, 0, 1),
                               pk(4'h5, 0, 1), pk(4'hF, 0, 1)};
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back(ex[i]);
            cyc(r[i], 1'b1, v[i]);
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL back_to_back[%0d] got %h expected %h", i, got, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_pass();
        test_fire();
        test_reset_fired();
        test_nomatch_overlap();
        test_en_gap();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/hwt_seq_trigger.md
Name: hwt_seq_trigger

Overview:
- Sequential trigger stage that sits directly upstream of the combinational non-active trojan cell and drives its A/B/C/D inputs.
- Registers the four input bits and feeds them downstream after one cycle.
- Watches the 4-bit vector {A,B,C,D} (A = MSB) for a rare three-step pattern.
- After THRESH complete occurrences it fires a sticky trigger. The payload forces the downstream D input low, so the downstream Y = D & ((A&B) | C) is held at 0.

Parameters:
- P0, 4'hA, first pattern in the sequence, compared against {A,B,C,D}.
- P1, 4'h5, second pattern.
- P2, 4'hF, third pattern. P0, P1 and P2 must be pairwise distinct.
- THRESH, 3, number of complete sequences needed to fire; legal range 1..2^CNT_W-1.
- CNT_W, 4, width of the occurrence counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- en  input  1  sample enable for the sequence monitor.
- A  input  1  monitored bit 3 (MSB).
- B  input  1  monitored bit 2.
- C  input  1  monitored bit 1.
- D  input  1  monitored bit 0.
- A_o  output  1  registered A, to downstream A.
- B_o  output  1  registered B, to downstream B.
- C_o  output  1  registered C, to downstream C.
- D_o  output  1  registered D gated by the payload, to downstream D.
- trig  output  1  sticky trigger flag (registered).
- match_cnt  output  CNT_W  number of completed sequences (observability).

Behaviour:
- Clock and reset: single clock domain. Reset is synchronous and active-low: when rst_n=0 at a rising edge, every register clears.
- Reset values: A_o=B_o=C_o=D_o=0, trig=0, match_cnt=0, FSM=IDLE.
- Reset mid-operation, including while FIRED, takes effect at that edge. No other mechanism clears trig.
- Pass-through: A_o/B_o/C_o track A/B/C with exactly 1-cycle latency, independent of en and FSM state.
- D_o = D_q & ~trig, where D_q is D registered and trig is a register. No combinational path from any input to any output.
- FSM: let v = {A,B,C,D}. The FSM advances only on edges where en=1; when en=0 the state and match_cnt hold.
  - IDLE: v==P0 -> S1; else stay in IDLE.
  - S1: v==P1 -> S2; v==P0 -> S1 (overlap restart); else -> IDLE.
  - S2, v==P2 (sequence complete):
    - match_cnt <= match_cnt+1.
    - If match_cnt+1 == THRESH -> FIRED, trig <= 1.
    - Otherwise -> IDLE.
  - S2, v!=P2: v==P0 -> S1; else -> IDLE.
  - FIRED: absorbing. Ignores en and v; match_cnt frozen.
- Priority in each state: advance match first, then the P0 restart, then fall back to IDLE.
- Trigger timing: trig rises on the same edge that samples the THRESH-th P2. From that edge on, D_o=0 regardless of D.
- match_cnt never wraps: it stops incrementing once FIRED, and THRESH <= 2^CNT_W-1.
- Sequence contiguity: the three patterns must occur on consecutive en=1 samples. en=0 cycles in between do not break the sequence.

Test Plan:
1. rst_n=0 for 2 edges with A..D=1 -> all outputs 0, match_cnt=0. Release -> outputs follow inputs one cycle later.
2. en=0, apply A,B,C,D = 1,1,0,1 -> next cycle A_o..D_o = 1,1,0,1 (downstream Y=1). Apply 0,0,1,1 -> outputs 0,0,1,1.
3. en=1, apply v = A,5,F three times back-to-back (9 cycles) with THRESH=3:
   - match_cnt reads 1 then 2 after the 1st and 2nd F edges.
   - trig=1 after the 9th edge.
   - Next cycle, with v=F applied, D_o=0 while A_o=B_o=C_o=1.
4. Apply v = A,5,3,F -> match_cnt stays 0. Then apply v = A,A,5,F -> match_cnt=1 (overlap restart).
5. Apply v=A (en=1), then two cycles of v=F with en=0, then 5 and F with en=1 -> match_cnt=1; A_o..D_o still pass through during the en=0 cycles.
6. While FIRED, assert rst_n=0 for 1 edge -> trig=0, match_cnt=0, FSM=IDLE. A single further A,5,F sequence gives match_cnt=1, trig=0.
